// File: rtl/eaglesong_sponge_ctrl.sv
// Sponge-mode initiator for the Eaglesong permutation: absorbs a byte-granular
// 32-bit word stream, applies DELIM padding, runs one permutation per block and returns the digest.
module eaglesong_sponge_ctrl #(
  parameter int         RATE_WORDS = 8,
  parameter logic [7:0] DELIM      = 8'h06
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  msg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic [31:0]  perm_state_out [0:15],
  output logic         perm_start,
  input  logic [31:0]  perm_state_in [0:15],
  input  logic         perm_done,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
);

  localparam logic [2:0] LAST_IDX = 3'(RATE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABSORB = 3'd1,
    S_PAD    = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_OUTPUT = 3'd5
  } fsm_t;

  fsm_t         fsm_r;
  fsm_t         fsm_next_s;
  logic [31:0]  state_r [0:15];
  logic [2:0]   word_idx_r;
  logic         pad_pending_r;
  logic         final_r;
  logic         msg_ready_r;
  logic         perm_start_r;
  logic         digest_valid_r;
  logic [255:0] digest_r;
  logic [255:0] digest_next_s;
  logic         accept_s;
  logic [2:0]   eff_bytes_s;
  logic         short_last_s;
  logic [3:0]   idx_s;

  // Keep bytes 0..n-1, place DELIM at byte n, zero the rest.
  function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [2:0] n);
    logic [31:0] w;
    case (n)
      3'd0:    w = {DELIM, 24'h000000};
      3'd1:    w = {data[31:24], DELIM, 16'h0000};
      3'd2:    w = {data[31:16], DELIM, 8'h00};
      3'd3:    w = {data[31:8], DELIM};
      default: w = data;
    endcase
    return w;
  endfunction

  assign accept_s     = msg_valid && msg_ready_r && (fsm_r == S_ABSORB);
  assign eff_bytes_s  = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
  assign short_last_s = msg_last && (eff_bytes_s < 3'd4);
  assign idx_s        = {1'b0, word_idx_r};

  // Next-state logic for the sponge sequencing FSM.
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      S_IDLE: fsm_next_s = S_ABSORB;
      S_ABSORB: begin
        if (!accept_s) begin
          fsm_next_s = S_ABSORB;
        end else if (short_last_s || (word_idx_r == LAST_IDX)) begin
          fsm_next_s = S_START;
        end else if (msg_last) begin
          fsm_next_s = S_PAD;
        end else begin
          fsm_next_s = S_ABSORB;
        end
      end
      S_PAD:   fsm_next_s = S_START;
      S_START: fsm_next_s = S_WAIT;
      S_WAIT: begin
        if (!perm_done) begin
          fsm_next_s = S_WAIT;
        end else if (final_r) begin
          fsm_next_s = S_OUTPUT;
        end else if (pad_pending_r) begin
          fsm_next_s = S_PAD;
        end else begin
          fsm_next_s = S_ABSORB;
        end
      end
      S_OUTPUT: begin
        if (digest_ready) begin
          fsm_next_s = S_IDLE;
        end else begin
          fsm_next_s = S_OUTPUT;
        end
      end
      default: fsm_next_s = S_IDLE;
    endcase
  end

  // Digest is the rate half of the permutation result, word 0 most significant.
  always_comb begin
    digest_next_s = '0;
    for (int i = 0; i < 8; i++) begin
      digest_next_s[255 - 32*i -: 32] = perm_state_in[i];
    end
  end

  // FSM register and registered handshake outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r          <= S_IDLE;
      msg_ready_r    <= 1'b0;
      perm_start_r   <= 1'b0;
      digest_valid_r <= 1'b0;
    end else begin
      fsm_r          <= fsm_next_s;
      msg_ready_r    <= (fsm_next_s == S_ABSORB);
      perm_start_r   <= (fsm_next_s == S_START);
      digest_valid_r <= (fsm_next_s == S_OUTPUT);
    end
  end

  // Sponge state, absorb index, padding flags and digest register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        state_r[i] <= 32'h0;
      end
      word_idx_r    <= 3'd0;
      pad_pending_r <= 1'b0;
      final_r       <= 1'b0;
      digest_r      <= 256'h0;
    end else begin
      case (fsm_r)
        S_IDLE: begin
          for (int i = 0; i < 16; i++) begin
            state_r[i] <= 32'h0;
          end
          word_idx_r    <= 3'd0;
          pad_pending_r <= 1'b0;
          final_r       <= 1'b0;
        end
        S_ABSORB: begin
          if (accept_s) begin
            if (short_last_s) begin
              state_r[idx_s] <= state_r[idx_s] ^ pad_word(msg_data, eff_bytes_s);
              final_r        <= 1'b1;
            end else begin
              state_r[idx_s] <= state_r[idx_s] ^ msg_data;
              word_idx_r     <= word_idx_r + 3'd1;
              if (msg_last) begin
                pad_pending_r <= 1'b1;
              end
            end
          end
        end
        S_PAD: begin
          state_r[idx_s] <= state_r[idx_s] ^ {DELIM, 24'h000000};
          pad_pending_r  <= 1'b0;
          final_r        <= 1'b1;
        end
        S_WAIT: begin
          if (perm_done) begin
            for (int i = 0; i < 16; i++) begin
              state_r[i] <= perm_state_in[i];
            end
            word_idx_r <= 3'd0;
            if (final_r) begin
              digest_r <= digest_next_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State is presented to the permutation continuously.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      perm_state_out[i] = state_r[i];
    end
  end

  assign msg_ready    = msg_ready_r;
  assign perm_start   = perm_start_r;
  assign digest_valid = digest_valid_r;
  assign digest       = digest_r;

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Self-checking bench: byte-level sponge reference model plus a configurable permutation stub.
module tb_eaglesong_sponge_ctrl;

  typedef logic [15:0][31:0] st_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic         msg_last;
  logic [2:0]   msg_bytes;
  logic [31:0]  perm_state_out [0:15];
  logic         perm_start;
  logic [31:0]  perm_state_in [0:15];
  logic         perm_done;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  int checks = 0;
  int errors = 0;

  int   stub_mode = 0;
  int   stub_lat = 3;
  bit   stub_glitch = 1'b0;
  int   cd = 0;
  st_t  resp;
  st_t  cap_q[$];

  logic [7:0]   msg_q[$];
  st_t          exp_pre[$];
  logic [255:0] exp_digest;

  eaglesong_sponge_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
    .perm_state_out(perm_state_out), .perm_start(perm_start),
    .perm_state_in(perm_state_in), .perm_done(perm_done),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready)
  );

  always #5 clk = ~clk;

  // Environment permutation: 0 identity, 1 bitwise invert, 2 word mixing.
  function automatic st_t perm_fn(input int mode, input st_t s);
    st_t o;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      a = s[(i + 3) % 16];
      case (mode)
        0: o[i] = s[i];
        1: o[i] = ~s[i];
        default: o[i] = {a[26:0], a[31:27]} ^ s[i] ^ (32'h9E3779B9 * 32'(i + 1));
      endcase
    end
    return o;
  endfunction

  function automatic bit state_is_zero();
    bit z = 1'b1;
    for (int i = 0; i < 16; i++) if (perm_state_out[i] !== 32'h0) z = 1'b0;
    return z;
  endfunction

  // Permutation stub: captures the presented state on perm_start, answers after stub_lat cycles.
  always @(negedge clk) begin
    st_t cur;
    perm_done = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        perm_done = 1'b1;
        for (int i = 0; i < 16; i++) perm_state_in[i] = resp[i];
      end
    end
    if (perm_start === 1'b1) begin
      for (int i = 0; i < 16; i++) cur[i] = perm_state_out[i];
      cap_q.push_back(cur);
      resp = perm_fn(stub_mode, cur);
      cd = stub_lat;
      if (stub_glitch) begin
        perm_done = 1'b1;
        for (int i = 0; i < 16; i++) perm_state_in[i] = $urandom;
      end
    end
  end

  // Reference: pad bytes with 0x06 then zeros to 32-byte blocks, absorb into rate words, permute.
  task automatic build_model(input int mode);
    logic [7:0]  p[$];
    st_t         st;
    logic [31:0] w;
    p = msg_q;
    p.push_back(8'h06);
    while (p.size() % 32 != 0) p.push_back(8'h00);
    st = '0;
    exp_pre.delete();
    for (int b = 0; b < p.size() / 32; b++) begin
      for (int k = 0; k < 8; k++) begin
        w = {p[b*32 + 4*k], p[b*32 + 4*k + 1], p[b*32 + 4*k + 2], p[b*32 + 4*k + 3]};
        st[k] = st[k] ^ w;
      end
      exp_pre.push_back(st);
      st = perm_fn(mode, st);
    end
    for (int i = 0; i < 8; i++) exp_digest[255 - 32*i -: 32] = st[i];
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb, input bit throttle);
    int guard = 0;
    if (throttle) begin
      msg_valid = 1'b0;
      @(negedge clk);
    end
    msg_data = d; msg_last = last; msg_bytes = nb; msg_valid = 1'b1;
    while (msg_ready !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL msg_accept_timeout: msg_ready=%b required 1", msg_ready);
    end
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0; msg_data = $urandom;
  endtask

  task automatic run_msg(input string name, input int mode, input int lat, input bit throttle,
                         input int hold, input bit ff_fill, input bit glitch, input bit rand_tail);
    int L, nfull, rem, guard;
    logic [31:0]  w;
    bit           extra_zero, ready_seen, stable_ok;
    logic [255:0] held;
    stub_mode = mode; stub_lat = lat; stub_glitch = glitch;
    cap_q.delete();
    build_model(mode);
    L = msg_q.size(); nfull = L / 4; rem = L % 4;
    extra_zero = (L == 0) || (rem == 0 && rand_tail && ($urandom_range(0, 1) == 1));
    for (int k = 0; k < nfull; k++) begin
      w = {msg_q[4*k], msg_q[4*k + 1], msg_q[4*k + 2], msg_q[4*k + 3]};
      if (k == nfull - 1 && rem == 0 && !extra_zero)
        send_word(w, 1'b1, rand_tail ? 3'($urandom_range(4, 7)) : 3'd4, throttle);
      else
        send_word(w, 1'b0, 3'($urandom_range(0, 7)), throttle);
    end
    if (rem > 0 || extra_zero) begin
      w = ff_fill ? 32'hFFFFFFFF : $urandom;
      for (int j = 0; j < rem; j++) w[31 - 8*j -: 8] = msg_q[4*nfull + j];
      send_word(w, 1'b1, 3'(rem), throttle);
    end
    ready_seen = 1'b0; guard = 0;
    while (digest_valid !== 1'b1 && guard < 1000) begin
      if (msg_ready !== 1'b0) ready_seen = 1'b1;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL %s digest_timeout: digest_valid=%b required 1", name, digest_valid);
    end
    checks++;
    if (ready_seen) begin
      errors++;
      $display("FAIL %s msg_ready_after_last: saw 1 required 0", name);
    end
    checks++;
    if (digest !== exp_digest) begin
      errors++;
      $display("FAIL %s digest: got %h required %h", name, digest, exp_digest);
    end
    held = digest; stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (digest_valid !== 1'b1 || digest !== held || msg_ready !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (!stable_ok) begin
        errors++;
        $display("FAIL %s digest_hold: valid=%b ready=%b digest=%h required stable %h", name,
                 digest_valid, msg_ready, digest, held);
      end
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    checks++;
    if (digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s digest_valid_drop: got %b required 0", name, digest_valid);
    end
    checks++;
    if (cap_q.size() != exp_pre.size()) begin
      errors++;
      $display("FAIL %s perm_start_count: got %0d required %0d", name, cap_q.size(), exp_pre.size());
    end else begin
      for (int b = 0; b < exp_pre.size(); b++) begin
        checks++;
        if (cap_q[b] !== exp_pre[b]) begin
          errors++;
          $display("FAIL %s block%0d_state: got %h required %h", name, b, cap_q[b], exp_pre[b]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (msg_ready !== 1'b0 || perm_start !== 1'b0 || digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b start=%b valid=%b required 0 0 0", msg_ready, perm_start, digest_valid);
    end
    checks++;
    if (digest !== 256'h0 || !state_is_zero()) begin
      errors++;
      $display("FAIL reset_data: digest=%h state0=%h required 0", digest, perm_state_out[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", msg_ready);
    end
  endtask

  task automatic test_empty();
    st_t e;
    msg_q.delete();
    run_msg("empty", 0, 3, 1'b0, 10, 1'b1, 1'b0, 1'b0);
    e = '0;
    e[0] = 32'h06000000;
    checks++;
    if (cap_q.size() != 1 || cap_q[0] !== e) begin
      errors++;
      $display("FAIL empty_block: starts=%0d state0=%h required 1 06000000", cap_q.size(), cap_q[0][0]);
    end
  endtask

  task automatic test_one_word();
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("one_word", 0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (digest_ready === 1'b0 && exp_digest[255:224] !== 32'h61626306) begin
      errors++;
      $display("FAIL one_word_model: got %h required 61626306", exp_digest[255:224]);
    end
  endtask

  task automatic test_eight_words();
    msg_q.delete();
    for (int k = 1; k <= 8; k++) begin
      msg_q.push_back(8'h00); msg_q.push_back(8'h00); msg_q.push_back(8'h00); msg_q.push_back(8'(k));
    end
    run_msg("eight_words", 0, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nine_words();
    msg_q.delete();
    for (int k = 1; k <= 8; k++) begin
      msg_q.push_back(8'h00); msg_q.push_back(8'h00); msg_q.push_back(8'h00); msg_q.push_back(8'(k));
    end
    msg_q.push_back(8'hAB); msg_q.push_back(8'hCD);
    run_msg("nine_words", 1, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_throttle();
    msg_q.delete();
    for (int i = 0; i < 45; i++) msg_q.push_back(8'($urandom));
    run_msg("unthrottled", 2, 3, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_msg("throttled", 2, 5, 1'b1, 10, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) begin
      int len;
      len = $urandom_range(0, 100);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rand%0d_len%0d", n, len), $urandom_range(0, 2), $urandom_range(1, 6),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bit ok = 1'b1;
    stub_mode = 0; stub_lat = 20; stub_glitch = 1'b0;
    cap_q.delete();
    send_word(32'hFFFFFFFF, 1'b1, 3'd0, 1'b0);
    while (cap_q.size() == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (msg_ready !== 1'b0 || perm_start !== 1'b0 || digest_valid !== 1'b0 || digest !== 256'h0 || !state_is_zero()) begin
      errors++;
      $display("FAIL reset_mid: ready=%b start=%b valid=%b state0=%h required all 0",
               msg_ready, perm_start, digest_valid, perm_state_out[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (!state_is_zero() || digest_valid !== 1'b0 || perm_start !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_mid_stale_done: state0=%h valid=%b required 0 0", perm_state_out[0], digest_valid);
    end
    msg_q.delete();
    run_msg("empty_after_reset", 0, 3, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    msg_data = 32'h0; msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = 3'd0;
    digest_ready = 1'b0; perm_done = 1'b0;
    for (int i = 0; i < 16; i++) perm_state_in[i] = 32'h0;
    test_reset();
    test_empty();
    test_one_word();
    test_eight_words();
    test_nine_words();
    test_throttle();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
